// File: rtl/i2c_pkg.sv
// Shared types and widths for the I2C target: FSM state encoding and field sizes.
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W = 7;
  localparam int unsigned I2C_BYTE_W = 8;
  localparam int unsigned I2C_CNT_W  = 3;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WRITE,
    ST_WRITE_ACK,
    ST_READ,
    ST_READ_ACK,
    ST_WAIT_STOP
  } i2c_slave_state_t;

endpackage

// File: rtl/i2c_slave_if.sv
// Bus-side and user-side signals of the I2C target grouped for port connection.
interface i2c_slave_if;
  import i2c_pkg::*;

  logic                  scl_in;
  logic                  sda_in;
  logic                  sda_oe;
  logic [I2C_BYTE_W-1:0] tx_data;
  logic                  tx_ack;
  logic [I2C_BYTE_W-1:0] rx_data;
  logic                  rx_valid;
  logic                  addr_match;
  logic                  rw;
  logic                  busy;

  modport slave (
    input  scl_in, sda_in, tx_data,
    output sda_oe, tx_ack, rx_data, rx_valid, addr_match, rw, busy
  );

  modport master (
    output scl_in, sda_in, tx_data,
    input  sda_oe, tx_ack, rx_data, rx_valid, addr_match, rw, busy
  );

endinterface

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA and decodes registered one-cycle pulses for SCL edges, START and STOP.
module i2c_bus_sync (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop,
  output logic sda_level
);

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_prev;
  logic       sda_prev;

  // Idle bus is high, so all history flops reset to 1 to avoid a false event after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync  <= 2'b11;
      sda_sync  <= 2'b11;
      scl_prev  <= 1'b1;
      sda_prev  <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start     <= 1'b0;
      stop      <= 1'b0;
      sda_level <= 1'b1;
    end else begin
      scl_sync  <= {scl_sync[0], scl_in};
      sda_sync  <= {sda_sync[0], sda_in};
      scl_prev  <= scl_sync[1];
      sda_prev  <= sda_sync[1];
      scl_rise  <=  scl_sync[1] & ~scl_prev;
      scl_fall  <= ~scl_sync[1] &  scl_prev;
      start     <=  scl_sync[1] &  scl_prev &  sda_prev & ~sda_sync[1];
      stop      <=  scl_sync[1] &  scl_prev & ~sda_prev &  sda_sync[1];
      sda_level <=  sda_sync[1];
    end
  end

endmodule

// File: rtl/i2c_slave.sv
// I2C target: address match, ACK generation, write-byte receive and read-byte serialisation.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'h6B
) (
  input  logic        clk,
  input  logic        reset,
  i2c_slave_if.slave  bus
);

  logic scl_rise, scl_fall, start, stop, sda_level;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (bus.scl_in),
    .sda_in    (bus.sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start     (start),
    .stop      (stop),
    .sda_level (sda_level)
  );

  i2c_slave_state_t      state_q, state_d;
  logic [I2C_CNT_W-1:0]  cnt_q, cnt_d;
  logic [I2C_BYTE_W-1:0] shreg_q, shreg_d;
  logic [I2C_BYTE_W-1:0] rx_data_q, rx_data_d;
  logic                  sda_oe_q, sda_oe_d;
  logic                  tx_ack_q, tx_ack_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  addr_match_q, addr_match_d;
  logic                  rw_q, rw_d;
  logic                  busy_q, busy_d;
  logic                  acked_q, acked_d;
  logic [I2C_BYTE_W-1:0] byte_in;

  assign byte_in = {shreg_q[I2C_BYTE_W-2:0], sda_level};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      shreg_q      <= '0;
      rx_data_q    <= '0;
      sda_oe_q     <= 1'b0;
      tx_ack_q     <= 1'b0;
      rx_valid_q   <= 1'b0;
      addr_match_q <= 1'b0;
      rw_q         <= I2C_RW_WRITE;
      busy_q       <= 1'b0;
      acked_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      rx_data_q    <= rx_data_d;
      sda_oe_q     <= sda_oe_d;
      tx_ack_q     <= tx_ack_d;
      rx_valid_q   <= rx_valid_d;
      addr_match_q <= addr_match_d;
      rw_q         <= rw_d;
      busy_q       <= busy_d;
      acked_q      <= acked_d;
    end
  end

  // In the ACK states sda_oe doubles as the "first fall already seen" marker.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shreg_d      = shreg_q;
    rx_data_d    = rx_data_q;
    sda_oe_d     = sda_oe_q;
    rw_d         = rw_q;
    busy_d       = busy_q;
    acked_d      = acked_q;
    tx_ack_d     = 1'b0;
    rx_valid_d   = 1'b0;
    addr_match_d = 1'b0;

    if (stop) begin
      state_d  = ST_IDLE;
      busy_d   = 1'b0;
      sda_oe_d = 1'b0;
      acked_d  = 1'b0;
    end else if (start) begin
      state_d  = ST_ADDR;
      cnt_d    = '0;
      busy_d   = 1'b1;
      sda_oe_d = 1'b0;
      acked_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_ADDR: begin
          if (scl_rise) begin
            shreg_d = byte_in;
            cnt_d   = cnt_q + I2C_CNT_W'(1);
            if (cnt_q == I2C_CNT_W'(7)) begin
              if (byte_in[I2C_BYTE_W-1:1] == SLAVE_ADDR) begin
                rw_d         = byte_in[0];
                addr_match_d = 1'b1;
                state_d      = ST_ADDR_ACK;
              end else begin
                state_d = ST_WAIT_STOP;
              end
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else if (rw_q == I2C_RW_WRITE) begin
              sda_oe_d = 1'b0;
              state_d  = ST_WRITE;
            end else begin
              shreg_d  = bus.tx_data;
              tx_ack_d = 1'b1;
              sda_oe_d = ~bus.tx_data[I2C_BYTE_W-1];
              cnt_d    = '0;
              state_d  = ST_READ;
            end
          end
        end
        ST_WRITE: begin
          if (scl_rise) begin
            shreg_d = byte_in;
            cnt_d   = cnt_q + I2C_CNT_W'(1);
            if (cnt_q == I2C_CNT_W'(7)) begin
              rx_data_d  = byte_in;
              rx_valid_d = 1'b1;
              state_d    = ST_WRITE_ACK;
            end
          end
        end
        ST_WRITE_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = ST_WRITE;
            end
          end
        end
        ST_READ: begin
          if (scl_fall) begin
            cnt_d = cnt_q + I2C_CNT_W'(1);
            if (cnt_q == I2C_CNT_W'(7)) begin
              sda_oe_d = 1'b0;
              state_d  = ST_READ_ACK;
            end else begin
              shreg_d  = {shreg_q[I2C_BYTE_W-2:0], 1'b0};
              sda_oe_d = ~shreg_q[I2C_BYTE_W-2];
            end
          end
        end
        ST_READ_ACK: begin
          if (scl_rise) begin
            if (!sda_level) begin
              acked_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = ST_WAIT_STOP;
            end
          end else if (scl_fall && acked_q) begin
            acked_d  = 1'b0;
            shreg_d  = bus.tx_data;
            tx_ack_d = 1'b1;
            sda_oe_d = ~bus.tx_data[I2C_BYTE_W-1];
            cnt_d    = '0;
            state_d  = ST_READ;
          end
        end
        ST_WAIT_STOP: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign bus.sda_oe     = sda_oe_q;
  assign bus.tx_ack     = tx_ack_q;
  assign bus.rx_data    = rx_data_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.addr_match = addr_match_q;
  assign bus.rw         = rw_q;
  assign bus.busy       = busy_q;

endmodule

// File: doc/i2c_slave.md
# i2c_slave

Bus-side I2C target that sits downstream of `I2C_master` on the shared SCL/SDA wires. It oversamples SCL/SDA on the system clock and detects START, repeated START and STOP. It matches a 7-bit address, ACKs, and then either receives write bytes into `rx_data` or serialises `tx_data` for reads. It is the receiving endpoint used to close the loop on master transactions in system and bench builds.

## Interface
- `SLAVE_ADDR`, default 7'h6B: 7-bit address this target responds to.
- `clk`  in  1  system clock; all logic on posedge.
- `reset`  in  1  asynchronous, active-low reset.
- `scl_in`  in  1  SCL bus level (resolved wire).
- `sda_in`  in  1  SDA bus level (resolved wire, includes own drive).
- `sda_oe`  out  1  1 = pull SDA low (open-drain); 0 = release.
- `tx_data`  in  8  byte returned on reads; sampled at load point.
- `tx_ack`  out  1  one-cycle pulse: `tx_data` captured, next byte may be presented.
- `rx_data`  out  8  last byte written by master.
- `rx_valid`  out  1  one-cycle pulse: `rx_data` updated.
- `addr_match`  out  1  one-cycle pulse: own address received.
- `rw`  out  1  R/W bit of the current transaction (1 = read).
- `busy`  out  1  high from START to STOP.

## Operation
- Input conditioning:
  - `scl_in`/`sda_in` each pass through a 2-flop synchroniser plus a previous-value register.
  - Events are decoded from the synchronised values: `scl_rise`, `scl_fall`.
  - START = SDA falls while SCL high and stable. STOP = SDA rises while SCL high and stable.
- States: IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP.
- Global overrides, applied in any state:
  - START: go to ADDR, clear the 3-bit bit counter, set `busy`=1, `sda_oe`=0.
  - STOP: go to IDLE, set `busy`=0, `sda_oe`=0. STOP takes priority only if both decode in the same cycle, which is impossible by construction.
- IDLE: wait for START.
- ADDR:
  - Shift SDA MSB-first on 8 `scl_rise` events: 7 address bits, then R/W.
  - After the 8th rise:
    - If match: latch `rw`, pulse `addr_match`, go to ADDR_ACK.
    - Otherwise: go to WAIT_STOP.
- ADDR_ACK:
  - On the next `scl_fall`, set `sda_oe`=1.
  - Hold through the 9th clock.
  - On the following `scl_fall`:
    - `rw`=0: release `sda_oe`, go to WRITE.
    - `rw`=1: capture `tx_data`, pulse `tx_ack`, drive bit 7, go to READ.
- WRITE:
  - Shift 8 bits on `scl_rise`.
  - After the 8th, update `rx_data` and pulse `rx_valid`. Go to WRITE_ACK.
- WRITE_ACK: ACK unconditionally, same drive/release timing as ADDR_ACK, then return to WRITE.
- READ:
  - On each `scl_fall`, set `sda_oe` = ~bit, MSB-first.
  - After the 8th bit's clock, release `sda_oe` on `scl_fall` and go to READ_ACK.
- READ_ACK: sample SDA on `scl_rise`.
  - Low (ACK): on the next `scl_fall`, capture `tx_data`, pulse `tx_ack`, drive bit 7, go to READ.
  - High (NACK): go to WAIT_STOP, `sda_oe`=0.
- WAIT_STOP: ignore the bus until START or STOP.
- Bit counter is 3 bits and wraps 7→0 at each byte boundary. No other arithmetic.

## Timing
- Reset values: `sda_oe`=0, `tx_ack`=0, `rx_data`=8'h00, `rx_valid`=0, `addr_match`=0, `rw`=0, `busy`=0; state IDLE; synchroniser flops = 1.
- Event latency: a pin change is decoded 3 `clk` cycles later (2 sync + 1 edge register).
- Outputs are registered. `sda_oe` and the pulse outputs change on the cycle after the decoding event.
- Pulses (`rx_valid`, `tx_ack`, `addr_match`) are exactly one cycle wide.
- Bus constraint: SCL high and low phases ≥ 4 `clk` each. SDA must be stable ≥ 4 `clk` around SCL edges. Behaviour outside this is undefined.
- Reset asserted mid-byte: immediate return to reset values. The partial byte is discarded with no pulse, and SDA is released asynchronously.
- START during ACK drive: `sda_oe` drops on the decode cycle and the new address phase begins.

## Structure
- Package `i2c_pkg`:
  - `i2c_slave_state_t` enum (4-bit).
  - `I2C_ADDR_W`=7, `I2C_BYTE_W`=8.
  - `I2C_RW_WRITE`=0, `I2C_RW_READ`=1.
- Sub-module `i2c_bus_sync`: synchronisers, edge registers and START/STOP/rise/fall decode. Outputs are one-cycle pulses plus synchronised SDA.
- `i2c_slave` holds the FSM, shift register, bit counter and output registers.

## Test plan
- Write 0x33 to 0x6B → `addr_match` pulse, `rw`=0, SDA low during both 9th clocks, `rx_valid` pulse with `rx_data`=8'h33, `busy` falls after STOP.
- Address 0x2A → no `addr_match`, `sda_oe` stays 0 through all 9 clocks, state WAIT_STOP until STOP, `rx_valid` never pulses.
- Read from 0x6B, `tx_data`=8'hA5, master ACKs then NACKs; `tx_data`=8'h3C for the second byte → SDA carries 10100101 then 00111100, two `tx_ack` pulses, `sda_oe`=0 after NACK.
- Write 0x6B then 0x11, repeated START, read 0x6B → `rw` changes 0→1, second `addr_match` pulse, read byte driven correctly.
- Assert `reset` after 4 data bits of a write → all outputs at reset values next cycle, `rx_valid` never pulses. A full write of 0x55 after release gives `rx_data`=8'h55.
- STOP injected mid-read byte → `sda_oe`=0 within 4 `clk`, state IDLE, `busy`=0.
